// File: rtl/pfc_flow_ctrl_tx.sv
// Per-class transmit pause controller for 802.3x PAUSE and 802.1Qbb PFC: one pause-quanta
// down-counter per traffic class, loaded on the rising edge of the RX decoder's valid level.
module pfc_flow_ctrl_tx #(
  parameter int unsigned NUM_CLASSES  = 8,
  parameter int unsigned QUANTA_SHIFT = 6,
  parameter int unsigned STAT_W       = 16
) (
  input  logic                      tx_clk,
  input  logic                      rst_n,
  input  logic                      tx_pause_en,
  input  logic                      pfc_mode,
  input  logic [NUM_CLASSES-1:0]    class_en_vec,
  input  logic [16*NUM_CLASSES-1:0] pause_quanta,
  input  logic                      pause_quanta_val,
  input  logic [NUM_CLASSES-1:0]    paused,
  input  logic                      stat_clr,
  output logic [NUM_CLASSES-1:0]    pause_apply,
  output logic [NUM_CLASSES-1:0]    pause_expired,
  output logic [STAT_W-1:0]         pause_frames
);

  localparam int unsigned CNT_W = 16 + QUANTA_SHIFT;

  logic                   v1_q, v2_q, v3_q;
  logic                   load;
  logic [CNT_W-1:0]       cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0]       cnt_d [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] expired_d, expired_q;
  logic [STAT_W-1:0]      frames_d, frames_q;

  // Sync chain doubles as the edge detector; cleared by reset so a held-high val reloads once.
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= pause_quanta_val;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  assign load = v2_q & ~v3_q;

  always_comb begin
    expired_d   = '0;
    pause_apply = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (load && pfc_mode && class_en_vec[i]) begin
        cnt_d[i] = {pause_quanta[16*i +: 16], {QUANTA_SHIFT{1'b0}}};
      end else if (load && !pfc_mode) begin
        cnt_d[i] = {pause_quanta[15:0], {QUANTA_SHIFT{1'b0}}};
      end else if ((cnt_q[i] != '0) && paused[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      // Covers both decrement-from-one and a zero-quanta load onto a running counter.
      expired_d[i]   = (cnt_q[i] != '0) && (cnt_d[i] == '0);
      pause_apply[i] = tx_pause_en && (cnt_q[i] != '0);
    end
  end

  always_comb begin
    frames_d = frames_q;
    if (stat_clr) begin
      frames_d = '0;
    end else if (load && (frames_q != '1)) begin
      frames_d = frames_q + STAT_W'(1);
    end
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= '0;
      end
      expired_q <= '0;
      frames_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      expired_q <= expired_d;
      frames_q  <= frames_d;
    end
  end

  assign pause_expired = expired_q;
  assign pause_frames  = frames_q;

endmodule
